// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-seeds from the received stream, verifies alignment, then free-runs and counts bit errors.
// Optional loss-of-lock detection is enabled by defining LFSR_CHECKER_LOSS_EN.
module lfsr_checker #(
  parameter int nbits       = 8,
  parameter int lock_count  = 16,
  parameter int loss_thresh = 4,
  parameter int err_bits    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [nbits-1:0]    tap,
  input  logic                in,
  input  logic                clr,
  output logic                locked,
  output logic                err_pulse,
  output logic [err_bits-1:0] err_count
);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  localparam int FW = $clog2(nbits + 1);
  localparam int MW = $clog2(lock_count + 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(nbits - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(lock_count - 1);
  localparam logic [err_bits-1:0] ERR_ONE = {{(err_bits-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [nbits-1:0]    w, w_nxt;
  logic [FW-1:0]       fill, fill_nxt;
  logic [MW-1:0]       match, match_nxt;
  logic [err_bits-1:0] cnt_nxt;
  logic                pred, miss, err_hit, loss_hit;

  assign pred    = ^(w & tap);
  assign miss    = in ^ pred;
  assign err_hit = en && (state == LOCKED) && miss;
  assign locked  = (state == LOCKED);

`ifdef LFSR_CHECKER_LOSS_EN
  localparam int LW = $clog2(loss_thresh + 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(loss_thresh - 1);

  logic [LW-1:0] loss_cnt, loss_nxt;

  assign loss_hit = err_hit && (loss_cnt == LOSS_LAST);

  always_comb begin
    loss_nxt = loss_cnt;
    if (state != LOCKED)
      loss_nxt = '0;
    else if (en)
      loss_nxt = (!miss || loss_hit) ? '0 : loss_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) loss_cnt <= '0;
    else      loss_cnt <= loss_nxt;
  end
`else
  assign loss_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= SEED;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        SEED:    if (fill == FILL_LAST) state_nxt = VERIFY;
        VERIFY: begin
          if (miss)                     state_nxt = SEED;
          else if (match == MATCH_LAST) state_nxt = LOCKED;
        end
        LOCKED:  if (loss_hit) state_nxt = SEED;
        default: state_nxt = SEED;
      endcase
    end
  end

  // Window, counters and error accounting
  always_comb begin
    w_nxt     = w;
    fill_nxt  = fill;
    match_nxt = match;
    if (en) begin
      case (state)
        SEED: begin
          w_nxt     = {in, w[nbits-1:1]};
          fill_nxt  = (fill == FILL_LAST) ? '0 : fill + 1'b1;
          match_nxt = '0;
        end
        VERIFY: begin
          w_nxt     = {in, w[nbits-1:1]};
          fill_nxt  = '0;
          match_nxt = miss ? '0 : match + 1'b1;
        end
        LOCKED: begin
          // Free-running: the prediction, not the received bit, feeds the window.
          w_nxt    = {pred, w[nbits-1:1]};
          fill_nxt = '0;
        end
        default: begin
          w_nxt     = '0;
          fill_nxt  = '0;
          match_nxt = '0;
        end
      endcase
    end

    cnt_nxt = err_count;
    if (clr)
      cnt_nxt = err_hit ? ERR_ONE : '0;
    else if (err_hit && (err_count != {err_bits{1'b1}}))
      cnt_nxt = err_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w         <= '0;
      fill      <= '0;
      match     <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      w         <= w_nxt;
      fill      <= fill_nxt;
      match     <= match_nxt;
      err_pulse <= err_hit;
      err_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a reference generator feeds two instances (16-bit and 4-bit error counters).
// Loss-of-lock expectations follow LFSR_CHECKER_LOSS_EN.
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        in  = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  tap = 8'hB8;
  logic        locked, err_pulse, locked_s, err_pulse_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
  logic [7:0]  g;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.nbits(8), .lock_count(16), .loss_thresh(4), .err_bits(16)) dut (
    .clk(clk), .rst(rst), .en(en), .tap(tap), .in(in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count));

  lfsr_checker #(.nbits(8), .lock_count(16), .loss_thresh(4), .err_bits(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .tap(tap), .in(in), .clr(clr),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s));

  // One clock with optional bit inversion; the generator advances only on accepted bits.
  task automatic drive(input logic en_v, input logic flip, input logic clr_v);
    logic b;
    if (en_v) begin
      b  = ^(g & tap);
      g  = {b, g[7:1]};
      in = b ^ flip;
    end else begin
      in = 1'($urandom_range(0, 1));
    end
    en  = en_v;
    clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) begin
      en  = 1'($urandom_range(0, 1));
      in  = 1'($urandom_range(0, 1));
      clr = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    en  = 1'b0;
    g   = 8'h01;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: locked=%b err_pulse=%b err_count=%0d, want 0/0/0", locked, err_pulse, err_count);
    end
  endtask

  task automatic test_clean();
    int pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (i == 23) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL clean_early_lock: locked=%b after 23 bits, want 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_lock: locked=%b after 24 bits, want 1", locked);
    end
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (err_count !== 16'd0 || pulses != 0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_run: err_count=%0d pulses=%0d locked=%b, want 0/0/1", err_count, pulses, locked);
    end
  endtask

  task automatic test_single_flip();
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL flip: err_pulse=%b err_count=%0d locked=%b, want 1/1/1", err_pulse, err_count, locked);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL flip_pulse_width: err_pulse=%b, want 0", err_pulse);
    end
    repeat (100) drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL flip_no_multiply: err_count=%0d locked=%b, want 1/1", err_count, locked);
    end
  endtask

  task automatic test_verify_mismatch();
    do_reset();
    repeat (8) drive(1'b1, 1'b0, 1'b0);
    repeat (9) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL verify_miss: locked=%b err_pulse=%b, want 0/0", locked, err_pulse);
    end
    for (int i = 1; i <= 24; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (i == 23) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL verify_relock_early: locked=%b 23 bits after flip, want 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL verify_relock: locked=%b err_count=%0d 24 bits after flip, want 1/0", locked, err_count);
    end
  endtask

  task automatic test_loss();
    logic exp_locked;
`ifdef LFSR_CHECKER_LOSS_EN
    exp_locked = 1'b0;
`else
    exp_locked = 1'b1;
`endif
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: locked=%b after 3 errors, want 1", locked);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== exp_locked || err_count !== 16'd4 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL loss: locked=%b err_count=%0d err_pulse=%b, want %b/4/1", locked, err_count, err_pulse, exp_locked);
    end
  endtask

  task automatic test_gaps();
    int  accepted = 0;
    int  quiet_bad = 0;
    logic e;
    do_reset();
    for (int i = 0; i < 300 && accepted < 24; i++) begin
      e = ($urandom_range(0, 2) != 0);
      drive(e, 1'b0, 1'b0);
      if (e) begin
        accepted++;
        if (accepted == 23) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++;
            $display("FAIL gaps_early_lock: locked=%b after 23 accepted bits, want 0", locked);
          end
        end
      end
    end
    checks++;
    if (accepted != 24 || locked !== 1'b1) begin
      errors++;
      $display("FAIL gaps_lock: accepted=%0d locked=%b, want 24/1", accepted, locked);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (err_pulse !== 1'b0 || err_count !== 16'd0 || locked !== 1'b1) quiet_bad++;
    end
    checks++;
    if (quiet_bad != 0) begin
      errors++;
      $display("FAIL gaps_idle: %0d idle cycles changed outputs, want 0", quiet_bad);
    end
    repeat (20) drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL gaps_resume: err_count=%0d locked=%b, want 0/1", err_count, locked);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL clr_pre: err_count=%0d, want 2", err_count);
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_error: err_count=%0d err_pulse=%b, want 1/1", err_count, err_pulse);
    end
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (err_count !== 16'd0 || err_count_s !== 4'd0) begin
      errors++;
      $display("FAIL clr_plain: err_count=%0d err_count_s=%0d, want 0/0", err_count, err_count_s);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || locked_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: locked=%b locked_s=%b, want 0/0", locked, locked_s);
    end
    do_reset();
    repeat (24) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (err_count_s !== 4'd15 || locked_s !== 1'b1) begin
      errors++;
      $display("FAIL saturate: err_count_s=%0d locked_s=%b, want 15/1", err_count_s, locked_s);
    end
    checks++;
    if (err_count !== 16'd20 || locked !== 1'b1) begin
      errors++;
      $display("FAIL count20: err_count=%0d locked=%b, want 20/1", err_count, locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_flip();
    test_verify_mismatch();
    test_loss();
    test_gaps();
    test_clear();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker that sits directly downstream of the LFSR generator and consumes its `out` bit stream. It self-seeds a local copy of the generator's state from the incoming bits, confirms alignment, then free-runs and counts bit errors. It reports lock and a saturating error count for built-in self-test of LFSR-driven links.

## Interface
- `nbits`, 8: LFSR length; must match the generator.
- `lock_count`, 16: consecutive correct predictions required to declare lock, ≥1.
- `loss_thresh`, 4: consecutive errors in LOCKED that drop lock (only with the loss feature), ≥1.
- `err_bits`, 16: error counter width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  `in` carries a valid bit this cycle.
- `tap`  in  nbits  feedback taps, same encoding as the generator; held static while checking.
- `in`  in  1  received serial bit, i.e. the generator's `out`.
- `clr`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per detected error.
- `err_count`  out  err_bits  saturating error count.

## Operation
- Window register `w[nbits-1:0]`: `w[0]` is the oldest bit.
- Shift rule: `w <= {x, w[nbits-1:1]}`.
- Prediction: `pred = ^(w & tap)`, the expected next bit.
- FSM states:
  - SEED: each `en` shifts `in` into `w`. A fill counter runs 0..nbits-1. After the nbits-th accepted bit, go to VERIFY and zero the match counter.
  - VERIFY: each `en` shifts `in` into `w`.
    - `in==pred`: increment the match counter. On reaching `lock_count`, go to LOCKED.
    - `in!=pred`: go to SEED with the fill counter cleared. This is not counted as an error.
  - LOCKED: each `en` shifts `pred`, not `in`, into `w`. The checker free-runs, so a single flipped bit yields exactly one error (no error multiplication).
    - `in!=pred`: pulse `err_pulse` and increment `err_count`. `err_count` saturates at all-ones.
- Counting happens only in LOCKED.
- `clr`: `err_count` becomes 0. If an error occurs in the same cycle, `err_count` becomes 1.
- `en` low: no state, counter or window change; `err_pulse` is 0.
- `tap==0`: `pred` is always 0. Behaviour follows the rules above with no special case.

## Timing
- Reset values (`rst==0` at a clock edge): state SEED, fill and match counters 0, `w` 0, `locked` 0, `err_pulse` 0, `err_count` 0, loss counter 0. Reset mid-operation discards lock immediately.
- All outputs are registered and reflect the bit accepted on the previous edge.
- `locked` rises one cycle after the edge accepting the `lock_count`-th matching VERIFY bit. From reset with continuous `en`, that is nbits+lock_count accepted bits.
- `err_pulse` is high for exactly the cycle after the edge accepting the erroneous bit. `err_count` updates on that same edge.
- `locked` falls one cycle after the edge that triggers loss.

## Configuration
- `LFSR_CHECKER_LOSS_EN` defined:
  - LOCKED keeps a consecutive-error counter; any correct bit resets it to 0.
  - When it reaches `loss_thresh`, go to SEED, clear the fill counter and drop `locked`. The error on that bit is still counted.
- Undefined:
  - No loss logic. LOCKED holds until reset, and errors are counted indefinitely.

## Test plan
- Reset: drive `rst=0` for 2 cycles with random `in`/`en` → `locked=0`, `err_count=0`, `err_pulse=0`.
- Clean stream:
  - Setup: generator model with nbits=8, tap=8'hB8, seed=8'h01, continuous `en`.
  - Response: `locked` rises after exactly 24 accepted bits; `err_count` stays 0 over 1000 bits.
- Single flip after lock: one received bit inverted → one `err_pulse`, `err_count=1`, `locked` stays 1, no further errors.
- VERIFY mismatch: invert the 10th bit after seeding → returns to SEED with `locked` still 0; `locked` rises 24 bits after that flip.
- Loss (`LFSR_CHECKER_LOSS_EN`, loss_thresh=4): invert 4 consecutive bits after lock → `locked` falls the cycle after the 4th and `err_count=4`. Without the macro, `locked` stays 1 and `err_count=4`.
- Gaps, clear and saturation:
  - `en` toggled randomly: lock time counted in accepted bits only.
  - `clr` asserted in the same cycle as an error → `err_count=1`.
  - err_bits=4 with 20 injected errors → `err_count=15`.
